ext_unit_pipe: RTL

//  Parametrised, pipelined immediate-extension unit for the CDA3102 datapath, generalising the fixed 5->32 zero-extender.

---
 rtl/ext_unit_pipe.sv | 116 +++++++++++
 1 files changed

// File: rtl/ext_unit_pipe.sv
// Pipelined immediate-extension unit: ZE / SE / UPPER / SE<<2 of an IN_W-bit field to OUT_W bits,
// buffered in a two-entry valid/ready output queue with a completed-transfer counter.
module ext_unit_pipe #(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [IN_W-1:0]  A,
   input  logic [1:0]       MODE,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [OUT_W-1:0] Y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] XCNT
);

   if (IN_W < 1 || IN_W + 2 > OUT_W) begin : g_param_check
      $error("ext_unit_pipe: IN_W must lie in 1..OUT_W-2");
   end

   localparam int unsigned PadW = OUT_W - IN_W;

   typedef enum logic [1:0] {
      StEmpty,
      StOne,
      StTwo
   } state_e;

   state_e             state_q, state_d;
   logic [OUT_W-1:0]   head_q, head_d;
   logic [OUT_W-1:0]   tail_q, tail_d;
   logic               in_ready_q, in_ready_d;
   logic               out_valid_q, out_valid_d;
   logic [CNT_W-1:0]   xcnt_q, xcnt_d;

   logic [OUT_W-1:0]   se;
   logic [OUT_W-1:0]   ext;
   logic               push, pop;

   always_comb begin
      se  = {{PadW{A[IN_W-1]}}, A};
      ext = '0;
      unique case (MODE)
         2'b00:   ext = {{PadW{1'b0}}, A};
         2'b01:   ext = se;
         2'b10:   ext = {A, {PadW{1'b0}}};
         2'b11:   ext = se << 2;
         default: ext = '0;
      endcase
   end

   assign push = in_valid & in_ready_q;
   assign pop  = out_valid_q & out_ready;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      xcnt_d  = pop ? xcnt_q + 1'b1 : xcnt_q;
      unique case (state_q)
         StEmpty: begin
            if (push) begin
               head_d  = ext;
               state_d = StOne;
            end
         end
         StOne: begin
            if (push && pop) begin
               head_d = ext;
            end else if (push) begin
               tail_d  = ext;
               state_d = StTwo;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (pop) begin
               head_d  = tail_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
      // Handshake outputs are registered copies of the next occupancy.
      in_ready_d  = (state_d != StTwo);
      out_valid_d = (state_d != StEmpty);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StEmpty;
         head_q      <= '0;
         tail_q      <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         xcnt_q      <= '0;
      end else begin
         state_q     <= state_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         xcnt_q      <= xcnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign Y         = head_q;
   assign XCNT      = xcnt_q;

endmodule
